// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared state type and constants for the sipo_frame_rx serial frame receiver.
// The parity constant only matters when SIPO_PARITY_EN is defined.
package sipo_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } rx_state_e;

   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

   // XOR over data bits and parity bit must equal this for a clean frame (even parity).
   localparam logic PARITY_EVEN = 1'b0;

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: WIDTH-bit shift register plus saturating bit counter for sipo_frame_rx.
// clear together with shift_en loads serial_in as bit 0 of a fresh frame.
module sipo_shift_core
   import sipo_rx_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             clear,
   input  logic             serial_in,
   output logic [WIDTH-1:0] word,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   logic [WIDTH-1:0] word_q, word_d, base_word;
   logic [CNT_W-1:0] count_q, count_d, base_count;

   always_comb begin
      base_word  = clear ? '0 : word_q;
      base_count = clear ? '0 : count_q;
      word_d     = base_word;
      count_d    = base_count;
      if (shift_en) begin
         if (MSB_FIRST) begin
            word_d = {base_word[WIDTH-2:0], serial_in};
         end else begin
            word_d = {serial_in, base_word[WIDTH-1:1]};
         end
         if (base_count != CNT_MAX) begin
            count_d = base_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q  <= '0;
         count_q <= '0;
      end else begin
         word_q  <= word_d;
         count_q <= count_d;
      end
   end

   assign word  = word_q;
   assign count = count_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: start-delimited serial frame receiver with registered valid/ready output and overrun flag.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per frame and the parity_err output.
module sipo_frame_rx
   import sipo_rx_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

   localparam int unsigned      CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   rx_state_e        state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             perr_q, perr_d;

   logic             shift_en, clear, commit, commit_perr;
   logic [WIDTH-1:0] core_word, final_word, commit_word;
   logic [CNT_W-1:0] core_count;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .CNT_W     (CNT_W)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (shift_en),
      .clear     (clear),
      .serial_in (serial_in),
      .word      (core_word),
      .count     (core_count)
   );

   // Word including the bit on the line this cycle, so a frame can commit on its final-bit edge.
   assign final_word = MSB_FIRST ? {core_word[WIDTH-2:0], serial_in}
                                 : {serial_in, core_word[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      shift_en    = 1'b0;
      clear       = 1'b0;
      commit      = 1'b0;
      commit_word = final_word;
      commit_perr = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_en = 1'b1;
               clear    = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (start) begin
               clear = 1'b1;
            end else if (core_count == LAST_IDX) begin
`ifdef SIPO_PARITY_EN
               state_d = PAR;
`else
               commit  = 1'b1;
               state_d = IDLE;
`endif
            end
         end
`ifdef SIPO_PARITY_EN
         PAR: begin
            if (start) begin
               shift_en = 1'b1;
               clear    = 1'b1;
               state_d  = SHIFT;
            end else begin
               commit      = 1'b1;
               commit_word = core_word;
               commit_perr = ((^core_word) ^ serial_in) != PARITY_EVEN;
               state_d     = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // A commit in the handshake cycle refills the register, so valid stays high.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      perr_d    = perr_q;
      overrun_d = 1'b0;
      if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
      if (commit) begin
         if (!valid_q || data_ready) begin
            data_d  = commit_word;
            perr_d  = commit_perr;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         perr_q    <= perr_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign busy       = (state_q != IDLE);
   assign overrun    = overrun_q;
   assign parity_err = perr_q;

endmodule
